// File: rtl/uv_spi_slv_if.sv
// uv_spi_slv_if
//   Bundle of the SPI pins and the tx/rx word streams of the SPI target.
//   slave  : the SPI target (uv_spi_slv) side.
//   master : the SPI master / software side that drives the pins and the tx stream.
// Signals:
//   spi_cs, spi_sck, spi_mosi   SPI pins into the target (cs active-low)
//   spi_miso, spi_miso_oe       SPI data out of the target and its pad enable
//   tx_data, tx_valid, tx_ready next word to transmit, valid/ready handshake
//   tx_underrun                 pulse: IDLE_WORD loaded instead of a buffered word
//   rx_data, rx_valid           last complete received word, update pulse
//   rx_abort                    pulse: frame ended with a partial word
interface uv_spi_slv_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  spi_cs;
  logic                  spi_sck;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_underrun;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_abort;

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, rx_abort
  );

  modport master (
    output spi_cs, spi_sck, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, rx_abort
  );
endinterface

// File: rtl/uv_spi_slv.sv
// uv_spi_slv
//   SPI target that oversamples cs/sck/mosi on clk, deserialises mosi into
//   words and serialises a software-supplied word onto miso. Full duplex,
//   MSB first, all four CPOL/CPHA modes. clk must be >= 8x the sck rate.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   en          block enable; 0 forces IDLE and drops miso_oe
//   cpol, cpha  SPI mode, captured only while IDLE
//   bus         uv_spi_slv_if.slave (SPI pins, tx and rx word streams)
//   busy        FSM not in IDLE
//
// state | meaning
// IDLE  | cs deasserted or block disabled; mode register tracks cpol/cpha
// LOAD  | one cycle after cs falls: first tx word moved into the shift register
// SHIFT | frame active: sample and shift on synchronised sck edges
module uv_spi_slv #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           cpol,
  input  logic           cpha,
  uv_spi_slv_if.slave    bus,
  output logic           busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  mode_cpol;
  logic                  mode_cpha;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic                  skip_shift;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rx_abort_q;
  logic                  underrun_q;
  logic                  miso_q;
  logic                  oe_q;
  logic                  busy_q;

  // pin synchronisers
  logic       cs_s1, cs_s2, cs_h;
  logic       sck_s1, sck_s2, sck_h;
  logic       mosi_s1, mosi_s2;
  logic [1:0] sync_fill;
  logic       cs_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_h      <= 1'b1;
      sck_s1    <= 1'b0;
      sck_s2    <= 1'b0;
      sck_h     <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      sync_fill <= 2'b00;
      cs_armed  <= 1'b0;
    end else begin
      cs_s1     <= bus.spi_cs;
      cs_s2     <= cs_s1;
      cs_h      <= cs_s2;
      sck_s1    <= bus.spi_sck;
      sck_s2    <= sck_s1;
      sck_h     <= sck_s2;
      mosi_s1   <= bus.spi_mosi;
      mosi_s2   <= mosi_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      // The cs pipeline resets to "deasserted"; if cs is really low when reset
      // releases, that would look like a falling edge. Only accept a falling
      // edge once cs has genuinely been seen high after the pipeline filled.
      if (sync_fill[1] && cs_s2)
        cs_armed <= 1'b1;
    end
  end

  logic cs_fall;
  logic sck_rise, sck_fall;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic leave;
  logic word_done;
  logic reload;
  logic [DATA_WIDTH-1:0] reload_word;

  assign cs_fall     = cs_armed & cs_h & ~cs_s2;
  assign sck_rise    = sck_s2 & ~sck_h;
  assign sck_fall    = ~sck_s2 & sck_h;
  assign lead_edge   = mode_cpol ? sck_fall : sck_rise;
  assign trail_edge  = mode_cpol ? sck_rise : sck_fall;
  assign sample_edge = mode_cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode_cpha ? lead_edge : trail_edge;
  assign leave       = cs_s2 | ~en;
  assign word_done   = (state == SHIFT) && (cnt == CNT_FULL);
  // A reload of the tx shift register happens on entry (LOAD) and at every
  // completed word, unless the frame is ending in the same cycle.
  assign reload      = !leave && ((state == LOAD) || word_done);
  assign reload_word = hold_full ? hold : IDLE_WORD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_cpol  <= 1'b0;
      mode_cpha  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      skip_shift <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
      underrun_q <= 1'b0;

      // hold_full is 1 whenever a reload empties it, so the two never collide.
      if (bus.tx_valid && !hold_full) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (reload) begin
        tx_sr  <= reload_word;
        miso_q <= reload_word[DATA_WIDTH-1];
        if (hold_full)
          hold_full <= 1'b0;
        else
          underrun_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          mode_cpol  <= cpol;
          mode_cpha  <= cpha;
          cnt        <= '0;
          skip_shift <= 1'b0;
          tx_sr      <= '0;
          miso_q     <= 1'b0;
          if (en && cs_fall) begin
            state  <= LOAD;
            oe_q   <= 1'b1;
            busy_q <= 1'b1;
          end
        end

        LOAD: begin
          if (leave) begin
            state  <= IDLE;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
            tx_sr  <= '0;
            miso_q <= 1'b0;
          end else begin
            // With cpha=1 the first leading edge would shift; the MSB is
            // already on miso, so that edge is swallowed.
            skip_shift <= mode_cpha;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (word_done) begin
            rx_data_q  <= rx_sr;
            rx_valid_q <= 1'b1;
            cnt        <= '0;
          end
          if (leave) begin
            state      <= IDLE;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            tx_sr      <= '0;
            miso_q     <= 1'b0;
            cnt        <= '0;
            rx_abort_q <= (cnt != '0) && !word_done;
          end else if (word_done) begin
            // keep the freshly reloaded MSB on miso across the next shift edge
            skip_shift <= 1'b1;
          end else if (sample_edge) begin
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_s2};
            cnt   <= cnt + 1'b1;
          end else if (shift_edge) begin
            if (skip_shift) begin
              skip_shift <= 1'b0;
            end else begin
              tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
              miso_q <= tx_sr[DATA_WIDTH-2];
            end
          end
        end

        default: begin
          state  <= IDLE;
          oe_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spi_miso    = miso_q & oe_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.tx_ready    = ~hold_full;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_abort    = rx_abort_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_uv_spi_slv.sv
// tb_uv_spi_slv
//   Bench for uv_spi_slv: a bit-banged SPI master drives the pins at clk/16,
//   expected rx words and miso words are queued as stimulus is issued, and a
//   negedge monitor checks every rx_valid against the rx queue.
module tb_uv_spi_slv;

  logic clk;
  logic rst;
  logic en;
  logic cpol;
  logic cpha;
  logic busy;

  uv_spi_slv_if #(.DATA_WIDTH(8)) bus ();

  uv_spi_slv #(
    .DATA_WIDTH(8),
    .IDLE_WORD (8'h5A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .cpol(cpol),
    .cpha(cpha),
    .bus (bus),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_under = 0;
  int n_abort = 0;
  int n_rxv = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  logic m_cpol;
  logic m_cpha;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        n_rxv++;
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected got %0h expected none at %0t", bus.rx_data, $time);
        end else begin
          chk("rx_word", {24'd0, bus.rx_data}, {24'd0, rx_q.pop_front()});
        end
      end
      if (bus.tx_underrun) n_under++;
      if (bus.rx_abort) n_abort++;
      if (!bus.spi_miso_oe) chk("miso_gated", {31'd0, bus.spi_miso}, 32'd0);
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    m_cpol = p;
    m_cpha = h;
    cpol = p;
    cpha = h;
    bus.spi_sck = p;
    wait_clk(4);
  endtask

  task automatic tx_push(input logic [7:0] d);
    chk("tx_ready_before_push", {31'd0, bus.tx_ready}, 32'd1);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
    chk("tx_ready_after_push", {31'd0, bus.tx_ready}, 32'd0);
  endtask

  task automatic frame_start();
    bus.spi_cs = 1'b0;
    wait_clk(16);
  endtask

  task automatic frame_end();
    bus.spi_cs = 1'b1;
    wait_clk(16);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 7 - k;
      if (!m_cpha) begin
        bus.spi_mosi = mo[i];
        mi[i] = bus.spi_miso;
        bus.spi_sck = ~m_cpol;
        wait_clk(8);
        bus.spi_sck = m_cpol;
        wait_clk(8);
      end else begin
        bus.spi_sck = ~m_cpol;
        bus.spi_mosi = mo[i];
        wait_clk(8);
        mi[i] = bus.spi_miso;
        bus.spi_sck = m_cpol;
        wait_clk(8);
      end
    end
  endtask

  task automatic word(input logic [7:0] mo);
    logic [7:0] mi;
    xfer(mo, 8, mi);
    if (tx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL miso_unexpected got %0h expected none", mi);
    end else begin
      chk("miso_word", {24'd0, mi}, {24'd0, tx_q.pop_front()});
    end
  endtask

  initial begin
    int u0, a0, v0;
    logic [7:0] dummy;

    rst = 1'b1;
    en = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    m_cpol = 1'b0;
    m_cpha = 1'b0;
    bus.spi_cs = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    wait_clk(3);
    chk("rst_miso", {31'd0, bus.spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
    chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {29'd0, bus.rx_valid, bus.tx_underrun, bus.rx_abort}, 32'd0);
    rst = 1'b0;
    wait_clk(5);

    // mode 0: preloaded 0xA5 out, 0x3C in
    set_mode(1'b0, 1'b0);
    tx_push(8'hA5);
    tx_q.push_back(8'hA5);
    rx_q.push_back(8'h3C);
    u0 = n_under; v0 = n_rxv;
    bus.spi_cs = 1'b0;
    wait_clk(6);
    chk("m0_tx_ready_load", {31'd0, bus.tx_ready}, 32'd1);
    chk("m0_busy", {31'd0, busy}, 32'd1);
    chk("m0_oe", {31'd0, bus.spi_miso_oe}, 32'd1);
    wait_clk(10);
    word(8'h3C);
    frame_end();
    chk("m0_rx_data", {24'd0, bus.rx_data}, 32'h3C);
    chk("m0_rxv_count", n_rxv - v0, 1);
    // the word-end reload finds the holding register empty
    chk("m0_underrun", n_under - u0, 1);

    // mode 3: two words in one frame, second tx word loaded during word 1
    set_mode(1'b1, 1'b1);
    tx_push(8'hF0);
    tx_q.push_back(8'hF0);
    tx_q.push_back(8'h0F);
    rx_q.push_back(8'h12);
    rx_q.push_back(8'h34);
    u0 = n_under; v0 = n_rxv;
    frame_start();
    fork
      word(8'h12);
      begin wait_clk(40); tx_push(8'h0F); end
    join
    fork
      word(8'h34);
      begin wait_clk(40); tx_push(8'h77); end
    join
    frame_end();
    chk("m3_rxv_count", n_rxv - v0, 2);
    chk("m3_underrun", n_under - u0, 0);

    // mode 1: empty holding register -> IDLE_WORD
    set_mode(1'b0, 1'b1);
    tx_q.push_back(8'h5A);
    rx_q.push_back(8'h96);
    u0 = n_under;
    frame_start();
    chk("m1_underrun_load", n_under - u0, 1);
    word(8'h96);
    frame_end();
    chk("m1_underrun_total", n_under - u0, 2);

    // mode 2: cs raised after 5 bits
    set_mode(1'b1, 1'b0);
    a0 = n_abort; v0 = n_rxv;
    frame_start();
    xfer(8'hFF, 5, dummy);
    bus.spi_cs = 1'b1;
    wait_clk(3);
    chk("m2_abort_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
    chk("m2_abort_busy", {31'd0, busy}, 32'd0);
    wait_clk(13);
    chk("m2_abort_count", n_abort - a0, 1);
    chk("m2_abort_no_rxv", n_rxv - v0, 0);
    chk("m2_rx_data_kept", {24'd0, bus.rx_data}, 32'h96);
    tx_q.push_back(8'h5A);
    rx_q.push_back(8'h81);
    frame_start();
    word(8'h81);
    frame_end();
    chk("m2_rx_data", {24'd0, bus.rx_data}, 32'h81);

    // cpol changed mid-frame is ignored
    set_mode(1'b0, 1'b0);
    tx_push(8'h3C);
    tx_q.push_back(8'h3C);
    rx_q.push_back(8'hE7);
    frame_start();
    cpol = 1'b1;
    word(8'hE7);
    frame_end();
    chk("cpol_frozen_rx", {24'd0, bus.rx_data}, 32'hE7);

    // en dropped mid-word
    set_mode(1'b0, 1'b0);
    a0 = n_abort;
    frame_start();
    xfer(8'h55, 3, dummy);
    en = 1'b0;
    wait_clk(3);
    chk("en_drop_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
    chk("en_drop_busy", {31'd0, busy}, 32'd0);
    chk("en_drop_abort", n_abort - a0, 1);
    en = 1'b1;
    wait_clk(10);
    chk("en_back_no_restart", {31'd0, busy}, 32'd0);
    frame_end();
    chk("en_drop_rx_kept", {24'd0, bus.rx_data}, 32'hE7);

    // reset in the middle of bit 4
    tx_push(8'h11);
    frame_start();
    xfer(8'h99, 4, dummy);
    rst = 1'b1;
    #1;
    chk("mid_rst_miso", {31'd0, bus.spi_miso}, 32'd0);
    chk("mid_rst_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
    chk("mid_rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("mid_rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_pulses", {29'd0, bus.rx_valid, bus.tx_underrun, bus.rx_abort}, 32'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(20);
    chk("post_rst_no_frame", {31'd0, busy}, 32'd0);
    frame_end();
    tx_q.push_back(8'h5A);
    rx_q.push_back(8'hC3);
    frame_start();
    word(8'hC3);
    frame_end();
    chk("post_rst_rx_data", {24'd0, bus.rx_data}, 32'hC3);

    chk("rx_queue_drained", rx_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
